// File: rtl/dsp_pipe_pkg.sv
// Shared definitions for the DSP operand/control pipeline registers.
//   CE_HOLD / CE_CLEAR : enable-low behaviour selectors for CE_MODE
//   occ_width(depth)   : width of an occupancy counter able to hold 0..depth
//   ch_lo(ch, width)   : low bit index of channel ch in a flattened bus
package dsp_pipe_pkg;

  localparam int CE_HOLD  = 0;
  localparam int CE_CLEAR = 1;

  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int ch_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline stage: a W-bit register (data plus valid packed together).
//   clk, rst  : clock, synchronous active-high reset
//   flush     : synchronous clear, below rst in priority
//   ce        : load d when high; when low hold or clear per CE_MODE
//   d / q     : stage input / registered output
module mux_pipe_stage
  import dsp_pipe_pkg::*;
#(
  parameter int W       = 19,
  parameter int CE_MODE = CE_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || flush)              q <= '0;
    else if (ce)                   q <= d;
    else if (CE_MODE == CE_CLEAR)  q <= '0;
  end

endmodule

// File: rtl/mux_pipe_reg.sv
// Multi-channel, DEPTH-stage operand pipeline with valid tracking, flush,
// registered occupancy count and selectable enable-low behaviour.
//   clk, rst   : clock, synchronous active-high reset
//   ce         : advance enable
//   flush      : synchronous clear of every stage
//   in_valid   : qualifies in
//   in         : NUM_CH*WIDTH bits, channel c at [c*WIDTH +: WIDTH]
//   out        : last-stage data (in when DEPTH=0)
//   out_valid  : last-stage valid (in_valid when DEPTH=0)
//   occupancy  : number of stages holding valid data
module mux_pipe_reg
  import dsp_pipe_pkg::*;
#(
  parameter  int WIDTH   = 18,
  parameter  int NUM_CH  = 1,
  parameter  int DEPTH   = 1,
  parameter  int CE_MODE = CE_HOLD,
  localparam int OCC_W   = occ_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic                    out_valid,
  output logic [OCC_W-1:0]        occupancy
);

  localparam int DW = NUM_CH * WIDTH;
  localparam int SW = DW + 1;   // valid rides in the MSB of each stage

  generate
    if (DEPTH == 0) begin : g_bypass
      // Pure wire: control inputs are intentionally ignored.
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, ce, flush};
      assign out        = in;
      assign out_valid  = in_valid;
      assign occupancy  = '0;
    end else begin : g_pipe
      logic [DEPTH:0][SW-1:0] stg;
      logic [DEPTH:0]         vld_pipe;
      logic [OCC_W-1:0]       occ_q;

      assign stg[0] = {in_valid, in};

      for (genvar k = 0; k < DEPTH; k++) begin : g_stg
        mux_pipe_stage #(.W(SW), .CE_MODE(CE_MODE)) u_stg (
          .clk   (clk),
          .rst   (rst),
          .flush (flush),
          .ce    (ce),
          .d     (stg[k]),
          .q     (stg[k+1])
        );
      end

      for (genvar k = 0; k <= DEPTH; k++) begin : g_vld
        assign vld_pipe[k] = stg[k][SW-1];
      end

      // Counter tracks entries minus exits; its clear conditions mirror the
      // stages exactly so it always equals the popcount of valid bits.
      always_ff @(posedge clk) begin
        if (rst || flush)
          occ_q <= '0;
        else if (ce)
          occ_q <= occ_q + OCC_W'(in_valid) - OCC_W'(vld_pipe[DEPTH]);
        else if (CE_MODE == CE_CLEAR)
          occ_q <= '0;
      end

      assign out       = stg[DEPTH][DW-1:0];
      assign out_valid = vld_pipe[DEPTH];
      assign occupancy = occ_q;
    end
  endgenerate

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Self-checking bench: five mux_pipe_reg configurations share one clock; a
// slot-array reference model per instance predicts out/out_valid, and the
// expected occupancy is the popcount of the model's valid slots.
module tb_mux_pipe_reg;
  import dsp_pipe_pkg::*;

  localparam int N = 5;
  localparam int DEP [N] = '{3, 1, 4, 2, 0};
  localparam int CEM [N] = '{0, 1, 0, 0, 0};
  localparam int DWD [N] = '{18, 18, 36, 24, 36};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [N];
  logic        ce_v  [N];
  logic        fl_v  [N];
  logic        iv_v  [N];
  logic [63:0] din   [N];
  logic [63:0] dout  [N];
  logic        ov    [N];
  logic [7:0]  occv  [N];

  logic [17:0] out0, out1;
  logic [35:0] out2, out4;
  logic [23:0] out3;
  logic [1:0]  occ0, occ3;
  logic        occ1, occ4;
  logic [2:0]  occ2;

  mux_pipe_reg #(.WIDTH(18), .NUM_CH(1), .DEPTH(3), .CE_MODE(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .flush(fl_v[0]), .in_valid(iv_v[0]),
    .in(din[0][17:0]), .out(out0), .out_valid(ov[0]), .occupancy(occ0));
  mux_pipe_reg #(.WIDTH(18), .NUM_CH(1), .DEPTH(1), .CE_MODE(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .flush(fl_v[1]), .in_valid(iv_v[1]),
    .in(din[1][17:0]), .out(out1), .out_valid(ov[1]), .occupancy(occ1));
  mux_pipe_reg #(.WIDTH(18), .NUM_CH(2), .DEPTH(4), .CE_MODE(0)) u2 (
    .clk(clk), .rst(rst_v[2]), .ce(ce_v[2]), .flush(fl_v[2]), .in_valid(iv_v[2]),
    .in(din[2][35:0]), .out(out2), .out_valid(ov[2]), .occupancy(occ2));
  mux_pipe_reg #(.WIDTH(8), .NUM_CH(3), .DEPTH(2), .CE_MODE(0)) u3 (
    .clk(clk), .rst(rst_v[3]), .ce(ce_v[3]), .flush(fl_v[3]), .in_valid(iv_v[3]),
    .in(din[3][23:0]), .out(out3), .out_valid(ov[3]), .occupancy(occ3));
  mux_pipe_reg #(.WIDTH(18), .NUM_CH(2), .DEPTH(0), .CE_MODE(0)) u4 (
    .clk(clk), .rst(rst_v[4]), .ce(ce_v[4]), .flush(fl_v[4]), .in_valid(iv_v[4]),
    .in(din[4][35:0]), .out(out4), .out_valid(ov[4]), .occupancy(occ4));

  assign dout[0] = 64'(out0);
  assign dout[1] = 64'(out1);
  assign dout[2] = 64'(out2);
  assign dout[3] = 64'(out3);
  assign dout[4] = 64'(out4);
  assign occv[0] = 8'(occ0);
  assign occv[1] = 8'(occ1);
  assign occv[2] = 8'(occ2);
  assign occv[3] = 8'(occ3);
  assign occv[4] = 8'(occ4);

  // Reference model: slot k holds the item that entered k+1 advances ago.
  logic [63:0] md [N][16];
  bit          mv [N][16];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] msk(input int w);
    return (64'h1 << w) - 64'h1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      if (DEP[i] == 0) continue;
      if (rst_v[i] || fl_v[i] || (!ce_v[i] && CEM[i] == 1)) begin
        for (int k = 0; k < 16; k++) begin md[i][k] = '0; mv[i][k] = 1'b0; end
      end else if (ce_v[i]) begin
        for (int k = DEP[i] - 1; k > 0; k--) begin
          md[i][k] = md[i][k-1];
          mv[i][k] = mv[i][k-1];
        end
        md[i][0] = din[i] & msk(DWD[i]);
        mv[i][0] = iv_v[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      logic [63:0] eo;
      logic        ev;
      int          pc;
      pc = 0;
      if (DEP[i] == 0) begin
        eo = din[i] & msk(DWD[i]);
        ev = iv_v[i];
      end else begin
        eo = md[i][DEP[i]-1];
        ev = mv[i][DEP[i]-1];
        for (int k = 0; k < DEP[i]; k++) pc += int'(mv[i][k]);
      end
      chk($sformatf("u%0d.out", i), dout[i], eo);
      chk($sformatf("u%0d.out_valid", i), 64'(ov[i]), 64'(ev));
      chk($sformatf("u%0d.occupancy", i), 64'(occv[i]), 64'(pc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      rst_v[i] = 1'b0; ce_v[i] = 1'b0; fl_v[i] = 1'b0; iv_v[i] = 1'b0; din[i] = '0;
    end
  endtask

  task automatic drive(input int i, input bit r, input bit c, input bit f,
                       input bit v, input logic [63:0] d);
    rst_v[i] = r; ce_v[i] = c; fl_v[i] = f; iv_v[i] = v; din[i] = d;
  endtask

  initial begin
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin md[i][k] = 64'hx; mv[i][k] = 1'b0; end
    idle_all();
    #2;
    // Reset everything.
    for (int i = 0; i < N; i++) rst_v[i] = 1'b1;
    tick();
    tick();
    idle_all();
    #1 check_all();

    // Basic fill of the 3-deep pipe; occupancy 1,2,3,3.
    drive(0, 0, 1, 0, 1, 64'h11); tick(); chk("t1.occ1", 64'(occ0), 64'd1);
    drive(0, 0, 1, 0, 1, 64'h22); tick(); chk("t1.occ2", 64'(occ0), 64'd2);
    drive(0, 0, 1, 0, 1, 64'h33); tick(); chk("t1.occ3", 64'(occ0), 64'd3);
    chk("t1.first_out", 64'(out0), 64'h11);
    chk("t1.first_valid", 64'(ov[0]), 64'd1);
    drive(0, 0, 1, 0, 1, 64'h44); tick(); chk("t1.occ4", 64'(occ0), 64'd3);
    chk("t1.second_out", 64'(out0), 64'h22);

    // Four-cycle stall, then drain in order.
    for (int s = 0; s < 4; s++) begin
      drive(0, 0, 0, 0, 1, 64'h3FFFF); tick();
      chk("t2.frozen_out", 64'(out0), 64'h22);
      chk("t2.frozen_occ", 64'(occ0), 64'd3);
    end
    drive(0, 0, 1, 0, 0, 64'h0); tick(); chk("t2.drain0", 64'(out0), 64'h33);
    tick(); chk("t2.drain1", 64'(out0), 64'h44);
    tick(); chk("t2.drain_empty_v", 64'(ov[0]), 64'd0);
    chk("t2.drain_empty_occ", 64'(occ0), 64'd0);

    // Legacy single register: ce low clears.
    drive(1, 0, 1, 0, 1, 64'h2AAAA); tick();
    chk("t3.load", 64'(out1), 64'h2AAAA);
    drive(1, 0, 0, 0, 1, 64'h2AAAA); tick();
    chk("t3.clr_out", 64'(out1), 64'h0);
    chk("t3.clr_v", 64'(ov[1]), 64'd0);
    chk("t3.clr_occ", 64'(occ1), 64'd0);

    // Fill the 4-deep pipe, then flush together with ce and a valid input.
    for (int s = 0; s < 4; s++) begin
      drive(2, 0, 1, 0, 1, {$urandom, $urandom}); tick();
    end
    chk("t4.full", 64'(occ2), 64'd4);
    drive(2, 0, 1, 1, 1, 64'hD_EADB_EEF0); tick();
    chk("t4.flush_occ", 64'(occ2), 64'd0);
    chk("t4.flush_v", 64'(ov[2]), 64'd0);
    chk("t4.flush_out", 64'(out2), 64'd0);
    for (int s = 0; s < 5; s++) begin
      drive(2, 0, 1, 0, 0, 64'h0); tick();
      chk("t4.no_ghost", 64'(ov[2]), 64'd0);
    end

    // Three 8-bit channels, then reset beating ce.
    drive(3, 0, 1, 0, 1, 64'hC3B2A1); tick();
    drive(3, 0, 1, 0, 0, 64'h0); tick();
    for (int c = 0; c < 3; c++) begin
      logic [63:0] cw;
      logic [63:0] ref_word;
      ref_word = 64'hC3B2A1;
      cw = (dout[3] >> ch_lo(c, 8)) & 64'hFF;
      chk($sformatf("t5.ch%0d", c), cw, (ref_word >> (8 * c)) & 64'hFF);
    end
    drive(3, 1, 1, 0, 1, 64'h5A5A5A); tick();
    chk("t5.rst_out", 64'(out3), 64'd0);
    chk("t5.rst_v", 64'(ov[3]), 64'd0);
    chk("t5.rst_occ", 64'(occ3), 64'd0);
    drive(3, 0, 0, 0, 0, 64'h0);

    // Bypass instance follows its inputs with no clock edge.
    @(negedge clk);
    drive(4, 1, 1, 1, 1, 64'hA_BCDE_1234); #1;
    chk("t6.bypass_out", 64'(out4), 64'hA_BCDE_1234);
    chk("t6.bypass_v", 64'(ov[4]), 64'd1);
    chk("t6.bypass_occ", 64'(occ4), 64'd0);
    drive(4, 0, 0, 0, 0, 64'h1_2345_6789); #1;
    chk("t6.bypass_out2", 64'(out4), 64'h1_2345_6789);
    chk("t6.bypass_v2", 64'(ov[4]), 64'd0);
    tick();

    // Randomized traffic on every instance.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++)
        drive(i, ($urandom_range(39) == 0), ($urandom_range(3) != 0),
              ($urandom_range(19) == 0), $urandom_range(1) == 1,
              {$urandom, $urandom});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
